// File: rtl/dac_write_ctrl.sv
// SPI master that writes a setpoint into the loop DAC and, when VERIFY is set,
// reads it back over two further frames and flags any difference.
module dac_write_ctrl #(
   parameter int WID       = 24,
   parameter int DATA_WID  = 20,
   parameter bit POLARITY  = 1'b0,
   parameter bit PHASE     = 1'b1,
   parameter int HALF_WAIT = 3,
   parameter int SS_WAIT   = 5,
   parameter bit VERIFY    = 1'b1
) (
   input  logic                clk,
   input  logic                rst_L,
   input  logic                arm,
   input  logic [DATA_WID-1:0] data,
   output logic                busy,
   output logic                finished,
   output logic                mismatch,
   output logic [DATA_WID-1:0] readback,
   output logic                sck,
   output logic                mosi,
   input  logic                miso,
   output logic                ss_L
);

   // Handshake: arm is accepted only in IDLE; finished stays high until arm drops.
   typedef enum logic [2:0] {IDLE, SS_SETUP, SHIFT, SS_GAP, DONE} state_t;

   localparam int CW = $clog2(SS_WAIT + 1);
   localparam int HW = $clog2(HALF_WAIT + 2);
   localparam int EW = $clog2(2 * WID + 1);
   localparam logic [3:0] CMD_WRITE = 4'b0001;
   localparam logic [3:0] CMD_READ  = 4'b1001;
   localparam logic [3:0] CMD_NOP   = 4'b0000;

   function automatic logic [WID-1:0] make_frame(input logic [3:0] cmd,
                                                 input logic [DATA_WID-1:0] val);
      make_frame = {cmd, {(WID-4){1'b0}}} | WID'(val);
   endfunction

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt;
   logic [HW-1:0]       hcnt;
   logic [EW-1:0]       ecnt;
   logic [1:0]          frame_idx;
   logic [WID-1:0]      tx;
   logic [WID-1:0]      rx;
   logic [DATA_WID-1:0] wdata;
   logic                cnt_done, half_done, last_edge, leading;

   assign cnt_done  = (cnt == CW'(SS_WAIT - 1));
   assign half_done = (hcnt == HW'(HALF_WAIT));
   assign last_edge = half_done && (ecnt == EW'(2 * WID - 1));
   assign leading   = ~ecnt[0];

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (arm && !finished) state_nxt = SS_SETUP;
         SS_SETUP: if (cnt_done) state_nxt = SHIFT;
         SHIFT:    if (last_edge) state_nxt = SS_GAP;
         SS_GAP:   if (cnt_done) state_nxt = (!VERIFY || frame_idx == 2'd2) ? DONE : SS_SETUP;
         DONE:     if (!arm) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      finished = 1'b0;
      ss_L     = 1'b1;
      case (state)
         SS_SETUP, SHIFT: begin
            busy = 1'b1;
            ss_L = 1'b0;
         end
         SS_GAP:  busy = 1'b1;
         DONE:    finished = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         sck       <= POLARITY;
         mosi      <= 1'b0;
         mismatch  <= 1'b0;
         readback  <= '0;
         cnt       <= '0;
         hcnt      <= '0;
         ecnt      <= '0;
         frame_idx <= '0;
         tx        <= '0;
         rx        <= '0;
         wdata     <= '0;
      end else begin
         case (state)
            IDLE: if (state_nxt == SS_SETUP) begin
               wdata     <= data;
               tx        <= make_frame(CMD_WRITE, data);
               frame_idx <= '0;
               mismatch  <= 1'b0;
               cnt       <= '0;
            end
            SS_SETUP: if (cnt_done) begin
               cnt  <= '0;
               hcnt <= '0;
               ecnt <= '0;
               // With PHASE=0 the MSB must be on the wire before the first edge.
               if (PHASE == 1'b0) begin
                  mosi <= tx[WID-1];
                  tx   <= {tx[WID-2:0], 1'b0};
               end
            end else begin
               cnt <= cnt + 1'b1;
            end
            SHIFT: if (half_done) begin
               hcnt <= '0;
               sck  <= ~sck;
               ecnt <= ecnt + 1'b1;
               if (leading == PHASE) begin
                  mosi <= tx[WID-1];
                  tx   <= {tx[WID-2:0], 1'b0};
               end else begin
                  rx <= {rx[WID-2:0], miso};
               end
            end else begin
               hcnt <= hcnt + 1'b1;
            end
            SS_GAP: if (cnt_done) begin
               cnt <= '0;
               if (state_nxt == DONE) begin
                  if (VERIFY) begin
                     readback <= rx[DATA_WID-1:0];
                     mismatch <= (rx[WID-1 -: 4] != CMD_READ) || (rx[DATA_WID-1:0] != wdata);
                  end
               end else begin
                  frame_idx <= frame_idx + 1'b1;
                  tx        <= (frame_idx == 2'd0) ? make_frame(CMD_READ, '0)
                                                   : make_frame(CMD_NOP, '0);
               end
            end else begin
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_write_ctrl.sv
// Bench for dac_write_ctrl: five DUT variants share one behavioural DAC slave,
// selected by sel; frames, readback, mismatch and latency are checked.
module tb_dac_write_ctrl;

   localparam int WID = 24;
   localparam int DW  = 20;
   localparam int HW  = 3;
   localparam int SSW = 5;
   localparam int FRAME_CYC = SSW + 2 * WID * (HW + 1) + SSW;
   localparam int LAT_WO = 1 + FRAME_CYC + 1;
   localparam int LAT_V  = 1 + 3 * FRAME_CYC + 1;

   logic          clk = 1'b0;
   logic          rst_L;
   logic          arm;
   logic [DW-1:0] data;
   logic [4:0]    arm_v;
   logic          busy_w [5];
   logic          fin_w  [5];
   logic          mm_w   [5];
   logic [DW-1:0] rb_w   [5];
   logic          sck_w  [5];
   logic          mosi_w [5];
   logic          ss_w   [5];
   logic          s_miso;
   logic          s_sck, s_mosi, s_ss;
   int            sel;
   logic          s_pol, s_pha;
   logic          pol_of [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic          pha_of [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   always_comb begin
      arm_v = '0;
      arm_v[sel] = arm;
   end

   assign s_sck  = sck_w[sel];
   assign s_mosi = mosi_w[sel];
   assign s_ss   = ss_w[sel];

   dac_write_ctrl #(.POLARITY(1'b0), .PHASE(1'b1), .VERIFY(1'b0)) d0 (
      .clk(clk), .rst_L(rst_L), .arm(arm_v[0]), .data(data), .busy(busy_w[0]),
      .finished(fin_w[0]), .mismatch(mm_w[0]), .readback(rb_w[0]), .sck(sck_w[0]),
      .mosi(mosi_w[0]), .miso(s_miso), .ss_L(ss_w[0]));
   dac_write_ctrl #(.POLARITY(1'b0), .PHASE(1'b1), .VERIFY(1'b1)) d1 (
      .clk(clk), .rst_L(rst_L), .arm(arm_v[1]), .data(data), .busy(busy_w[1]),
      .finished(fin_w[1]), .mismatch(mm_w[1]), .readback(rb_w[1]), .sck(sck_w[1]),
      .mosi(mosi_w[1]), .miso(s_miso), .ss_L(ss_w[1]));
   dac_write_ctrl #(.POLARITY(1'b0), .PHASE(1'b0), .VERIFY(1'b1)) d2 (
      .clk(clk), .rst_L(rst_L), .arm(arm_v[2]), .data(data), .busy(busy_w[2]),
      .finished(fin_w[2]), .mismatch(mm_w[2]), .readback(rb_w[2]), .sck(sck_w[2]),
      .mosi(mosi_w[2]), .miso(s_miso), .ss_L(ss_w[2]));
   dac_write_ctrl #(.POLARITY(1'b1), .PHASE(1'b1), .VERIFY(1'b1)) d3 (
      .clk(clk), .rst_L(rst_L), .arm(arm_v[3]), .data(data), .busy(busy_w[3]),
      .finished(fin_w[3]), .mismatch(mm_w[3]), .readback(rb_w[3]), .sck(sck_w[3]),
      .mosi(mosi_w[3]), .miso(s_miso), .ss_L(ss_w[3]));
   dac_write_ctrl #(.POLARITY(1'b1), .PHASE(1'b0), .VERIFY(1'b1)) d4 (
      .clk(clk), .rst_L(rst_L), .arm(arm_v[4]), .data(data), .busy(busy_w[4]),
      .finished(fin_w[4]), .mismatch(mm_w[4]), .readback(rb_w[4]), .sck(sck_w[4]),
      .mosi(mosi_w[4]), .miso(s_miso), .ss_L(ss_w[4]));

   // Behavioural DAC slave: write command stores curset, read command returns it next frame.
   logic [DW-1:0]  curset = '0;
   int             err_cnt = 0;
   logic [WID-1:0] resp = '0;
   logic [WID-1:0] s_tx, s_rx;
   int             s_cnt = 0;
   bit             in_frame = 1'b0;
   bit             corrupt = 1'b0;
   int             ss_falls = 0;
   logic [WID-1:0] frames_q [$];
   logic [WID-1:0] exp_q [$];

   always @(negedge s_ss) begin
      in_frame = 1'b1;
      s_cnt = 0;
      s_rx = '0;
      s_tx = resp;
      if (corrupt && resp[WID-1 -: 4] == 4'b1001) begin
         s_tx[0] = ~s_tx[0];
         corrupt = 1'b0;
      end
      ss_falls++;
      if (!s_pha) s_miso = s_tx[WID-1];
   end

   always @(posedge s_ss) begin
      #1 in_frame = 1'b0;
   end

   always @(s_sck) begin
      if (in_frame) begin
         if ((s_sck != s_pol) != s_pha) begin
            s_rx = {s_rx[WID-2:0], s_mosi};
            s_cnt++;
            if (s_cnt == WID) begin
               frames_q.push_back(s_rx);
               case (s_rx[WID-1 -: 4])
                  4'b0001: begin curset = s_rx[DW-1:0]; resp = '0; end
                  4'b1001: resp = {4'b1001, curset};
                  4'b0000: resp = '0;
                  default: begin err_cnt++; resp = '0; end
               endcase
            end
         end else if (s_cnt < WID) begin
            s_miso = s_tx[WID-1-s_cnt];
         end
      end
   end

   task automatic set_sel(input int i);
      sel   = i;
      s_pol = pol_of[i];
      s_pha = pha_of[i];
   endtask

   task automatic do_txn(input int idx, input logic [DW-1:0] val,
                         output int cycles, output bit timed_out);
      frames_q.delete();
      @(negedge clk);
      data = val;
      arm = 1'b1;
      cycles = 0;
      timed_out = 1'b1;
      for (int k = 0; k < 5000; k++) begin
         @(posedge clk);
         cycles++;
         if (cycles == 100) data = ~val;
         @(negedge clk);
         if (fin_w[idx] === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic drop_arm();
      @(negedge clk);
      arm = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic build_exp(input logic [DW-1:0] val, input bit verify);
      exp_q.delete();
      exp_q.push_back({4'b0001, val});
      if (verify) begin
         exp_q.push_back({4'b1001, 20'h0});
         exp_q.push_back({4'b0000, 20'h0});
      end
   endtask

   task automatic test_reset();
      rst_L = 1'b0;
      arm = 1'b0;
      data = '0;
      s_miso = 1'b0;
      set_sel(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_L = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({ss_w[i], sck_w[i], mosi_w[i], busy_w[i], fin_w[i], mm_w[i]} !==
             {1'b1, pol_of[i], 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs[%0d]: ss/sck/mosi/busy/fin/mm=%b%b%b%b%b%b want 1%b0000",
                     i, ss_w[i], sck_w[i], mosi_w[i], busy_w[i], fin_w[i], mm_w[i], pol_of[i]);
         end
         n_cmp++;
         if (rb_w[i] !== '0) begin
            n_err++;
            $display("FAIL reset_readback[%0d]: got %h want 0", i, rb_w[i]);
         end
      end
   endtask

   task automatic test_write_only();
      int cyc;
      bit to;
      int falls0;
      logic [DW-1:0] vals [3];
      vals[0] = 20'hABCDE;
      vals[1] = DW'($urandom);
      vals[2] = DW'($urandom);
      set_sel(0);
      for (int t = 0; t < 3; t++) begin
         falls0 = ss_falls;
         build_exp(vals[t], 1'b0);
         do_txn(0, vals[t], cyc, to);
         n_cmp++;
         if (to || cyc < LAT_WO - 1 || cyc > LAT_WO + 1) begin
            n_err++;
            $display("FAIL wo_latency: got %0d cycles (timeout=%0d) want %0d+-1", cyc, to, LAT_WO);
         end
         n_cmp++;
         if (curset !== vals[t]) begin
            n_err++;
            $display("FAIL wo_curset: got %h want %h", curset, vals[t]);
         end
         n_cmp++;
         if (busy_w[0] !== 1'b0 || fin_w[0] !== 1'b1) begin
            n_err++;
            $display("FAIL wo_done: busy=%b fin=%b want 0 1", busy_w[0], fin_w[0]);
         end
         n_cmp++;
         if (ss_falls - falls0 != 1 || frames_q.size() != 1 || frames_q[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL wo_frames: ss_falls=%0d frames=%0d want 1 frame %h",
                     ss_falls - falls0, frames_q.size(), exp_q[0]);
         end
         drop_arm();
         n_cmp++;
         if (fin_w[0] !== 1'b0) begin
            n_err++;
            $display("FAIL wo_fin_clear: got %b want 0", fin_w[0]);
         end
      end
   endtask

   task automatic test_verify(input int idx, input logic [DW-1:0] first, input int reps);
      int cyc;
      bit to;
      logic [DW-1:0] val;
      set_sel(idx);
      for (int t = 0; t < reps; t++) begin
         val = (t == 0) ? first : DW'($urandom);
         build_exp(val, 1'b1);
         do_txn(idx, val, cyc, to);
         n_cmp++;
         if (to || cyc < LAT_V - 1 || cyc > LAT_V + 1) begin
            n_err++;
            $display("FAIL v_latency[%0d]: got %0d cycles (timeout=%0d) want %0d+-1", idx, cyc, to, LAT_V);
         end
         n_cmp++;
         if (rb_w[idx] !== val || mm_w[idx] !== 1'b0) begin
            n_err++;
            $display("FAIL v_readback[%0d]: rb=%h mm=%b want %h 0", idx, rb_w[idx], mm_w[idx], val);
         end
         n_cmp++;
         if (frames_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL v_frame_count[%0d]: got %0d want %0d", idx, frames_q.size(), exp_q.size());
         end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
               n_cmp++;
               if (frames_q[k] !== exp_q[k]) begin
                  n_err++;
                  $display("FAIL v_frame%0d[%0d]: got %h want %h", k, idx, frames_q[k], exp_q[k]);
               end
            end
         end
         drop_arm();
         n_cmp++;
         if (sck_w[idx] !== pol_of[idx] || fin_w[idx] !== 1'b0) begin
            n_err++;
            $display("FAIL v_idle[%0d]: sck=%b fin=%b want %b 0", idx, sck_w[idx], fin_w[idx], pol_of[idx]);
         end
      end
   endtask

   task automatic test_corrupt();
      int cyc;
      bit to;
      set_sel(1);
      corrupt = 1'b1;
      do_txn(1, 20'h00001, cyc, to);
      n_cmp++;
      if (to || rb_w[1] !== 20'h00000 || mm_w[1] !== 1'b1) begin
         n_err++;
         $display("FAIL corrupt_detect: rb=%h mm=%b to=%0d want 00000 1", rb_w[1], mm_w[1], to);
      end
      drop_arm();
      n_cmp++;
      if (mm_w[1] !== 1'b1 || rb_w[1] !== 20'h00000) begin
         n_err++;
         $display("FAIL corrupt_hold: rb=%h mm=%b want 00000 1", rb_w[1], mm_w[1]);
      end
      do_txn(1, 20'h00002, cyc, to);
      n_cmp++;
      if (to || rb_w[1] !== 20'h00002 || mm_w[1] !== 1'b0) begin
         n_err++;
         $display("FAIL corrupt_recover: rb=%h mm=%b want 00002 0", rb_w[1], mm_w[1]);
      end
      drop_arm();
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit to;
      int falls0;
      set_sel(1);
      do_txn(1, 20'h00000, cyc, to);
      n_cmp++;
      if (to || rb_w[1] !== 20'h00000 || mm_w[1] !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_first: rb=%h mm=%b want 00000 0", rb_w[1], mm_w[1]);
      end
      falls0 = ss_falls;
      data = 20'hFFFFF;
      repeat (30) @(negedge clk);
      n_cmp++;
      if (ss_falls != falls0 || busy_w[1] !== 1'b0 || fin_w[1] !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_hold: extra ss=%0d busy=%b fin=%b want 0 0 1", ss_falls - falls0, busy_w[1], fin_w[1]);
      end
      drop_arm();
      do_txn(1, 20'hFFFFF, cyc, to);
      n_cmp++;
      if (to || rb_w[1] !== 20'hFFFFF || mm_w[1] !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_second: rb=%h mm=%b want FFFFF 0", rb_w[1], mm_w[1]);
      end
      drop_arm();
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit to;
      bit reached;
      logic [DW-1:0] cur0;
      int err0;
      set_sel(1);
      cur0 = curset;
      err0 = err_cnt;
      frames_q.delete();
      @(negedge clk);
      data = DW'($urandom);
      arm = 1'b1;
      reached = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (in_frame && s_cnt >= 10) begin
            reached = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!reached || frames_q.size() != 0) begin
         n_err++;
         $display("FAIL mid_reach: reached=%0d frames=%0d want 1 0", reached, frames_q.size());
      end
      rst_L = 1'b0;
      arm = 1'b0;
      #1;
      n_cmp++;
      if (ss_w[1] !== 1'b1 || sck_w[1] !== 1'b0 || fin_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: ss=%b sck=%b fin=%b busy=%b want 1 0 0 0", ss_w[1], sck_w[1], fin_w[1], busy_w[1]);
      end
      repeat (3) @(negedge clk);
      rst_L = 1'b1;
      n_cmp++;
      if (curset !== cur0 || err_cnt != err0) begin
         n_err++;
         $display("FAIL mid_dac: curset=%h err=%0d want %h %0d", curset, err_cnt, cur0, err0);
      end
      @(negedge clk);
      do_txn(1, 20'h0F0F0, cyc, to);
      n_cmp++;
      if (to || curset !== 20'h0F0F0 || rb_w[1] !== 20'h0F0F0 || mm_w[1] !== 1'b0) begin
         n_err++;
         $display("FAIL mid_recover: curset=%h rb=%h mm=%b want 0F0F0 0F0F0 0", curset, rb_w[1], mm_w[1]);
      end
      drop_arm();
   endtask

   initial begin
      test_reset();
      test_write_only();
      test_verify(1, 20'h12345, 3);
      test_corrupt();
      test_back_to_back();
      test_verify(2, 20'h5A5A5, 2);
      test_verify(3, 20'h5A5A5, 2);
      test_verify(4, 20'h5A5A5, 2);
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dac_write_ctrl.md
Name: dac_write_ctrl

Overview:
SPI master that writes a new setpoint into the control-loop DAC (dac_sim in simulation, the real DAC on hardware) and optionally reads it back to verify it. It sits directly upstream of the DAC SPI slave. It takes a DATA_WID-bit value through an arm/finished handshake and emits 24-bit DAC command frames.

Parameters:
WID, 24, SPI frame length in bits (4-bit command plus payload)
DATA_WID, 20, DAC value width; payload occupies frame bits [DATA_WID-1:0]
POLARITY, 0, SCK idle level
PHASE, 1, 1 = drive on leading edge and sample on trailing edge; 0 = drive before the leading edge and sample on the leading edge
HALF_WAIT, 3, SCK half-period is HALF_WAIT+1 clk cycles
SS_WAIT, 5, clk cycles ss_L is held high between frames, and cycles from ss_L falling to the first SCK edge
VERIFY, 1, 1 = perform readback after each write; 0 = write only

Ports:
clk  in  1  system clock
rst_L  in  1  asynchronous active-low reset
arm  in  1  request a write; sampled in IDLE
data  in  DATA_WID  value to write; captured on the cycle arm is accepted
busy  out  1  high from arm acceptance until finished rises
finished  out  1  transaction complete; held until arm goes low
mismatch  out  1  readback differed from the written value (valid when finished=1)
readback  out  DATA_WID  payload captured from the readback frame
sck  out  1  SPI clock
mosi  out  1  SPI data to DAC
miso  in  1  SPI data from DAC
ss_L  out  1  SPI select, active low

Behaviour:
- Reset (async assert, sync release): state IDLE; sck=POLARITY; ss_L=1; mosi=0; busy=0; finished=0; mismatch=0; readback=0. Reset mid-frame aborts immediately and leaves no partial state.
- States: IDLE, SS_SETUP, SHIFT, SS_GAP, DONE.
- IDLE: if arm=1 and finished=0, latch data into wdata, build the frame {4'b0001, zero pad, wdata}, set busy=1, and go to SS_SETUP. The frame counter selects frame 0.
- SS_SETUP: ss_L=0 for SS_WAIT cycles, then go to SHIFT.
- SHIFT: WID SCK periods, MSB first.
  - For PHASE=1, mosi updates on each leading edge and miso is sampled on each trailing edge.
  - For PHASE=0, bit WID-1 is placed on mosi at entry to SHIFT, mosi updates on trailing edges, and miso is sampled on leading edges.
  - After the WID-th sampling edge, sck returns to POLARITY and ss_L goes high, then go to SS_GAP.
- SS_GAP: hold for SS_WAIT cycles. Next frame:
  - VERIFY=0: DONE after frame 0.
  - VERIFY=1: frame 1 = {4'b1001, 0}, which is the read request.
  - Frame 2 = {4'b0000, 0}, a no-op that clocks out the response.
  - After frame 2, go to DONE.
- Readback check, on entry to DONE with VERIFY=1: readback = rx[DATA_WID-1:0] of frame 2. mismatch=1 if rx[WID-1:WID-4] != 4'b1001 or the payload != wdata. Received bits from frames 0 and 1 are discarded.
- DONE: finished=1 and busy=0. Stay until arm=0, then clear finished and return to IDLE. mismatch and readback hold until the next arm acceptance, which clears mismatch.
- arm and data changes while busy are ignored.
- Frame duration: WID*2*(HALF_WAIT+1) clk cycles of SHIFT.
  - With defaults, one write-only transaction runs from arm to finished in 1 + 5 + 192 + 5 + 1 cycles (±1 for the exact state edges).
  - The bench must check that finished rises within 1 cycle of the computed value.
- Payload width rule: when DATA_WID < WID-4, the bits between the command and the payload are zero on mosi and are ignored on readback.

Test Plan:
1. Write-only (VERIFY=0), data=20'hABCDE, arm pulse held high.
   - Required: dac_sim curset=20'hABCDE, finished=1, busy=0, ss_L asserted exactly once.
   - Then drop arm: finished clears the next cycle.
2. Verify path with defaults, data=20'h12345.
   - Required: 3 frames on mosi (0x112345, 0x900000, 0x000000), readback=20'h12345, mismatch=0.
3. Corrupted miso (force bit 0 of the frame-2 response inverted), data=20'h00001.
   - Required: readback=20'h00000, mismatch=1. A subsequent clean write of 20'h00002 gives mismatch=0.
4. Boundary values: data=20'h00000 and then 20'hFFFFF, back to back, arm held high between them.
   - Required: the second write starts only after arm falls and rises again, and both read back correctly.
5. Modes: POLARITY/PHASE = 0/0, 1/1, and 1/0 against a dac_sim with matching parameters, data=20'h5A5A5.
   - Required: readback matches, sck idles at POLARITY.
6. Reset mid-SHIFT: assert rst_L low at bit 10 of frame 0.
   - Required: ss_L=1, sck=POLARITY, finished=0, and busy=0 immediately. The dac_sim err/curset are unchanged.
   - The next full write of 20'h0F0F0 succeeds.
